hispi_word_align: RTL and testbench

//  Per-lane word-boundary trainer placed directly downstream of the HiSPi deserializer, in the clk_recover domain.

---
 rtl/hispi_word_align.sv | 175 +++++++++++++++++
 tb/tb_hispi_word_align.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hispi_word_align.sv
// Per-lane HiSPi word-boundary trainer: hunts for the 0xFFF,0x000 sync signature, steers the
// deserializer bitslip until it is found, then emits aligned double-chunk words with a strobe.
module hispi_word_align #(
    parameter int unsigned CHANNEL_NUM    = 4,
    parameter int unsigned DESER_WIDTH    = 6,
    parameter int unsigned SEARCH_TIMEOUT = 1024,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned LOSS_COUNT     = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [DESER_WIDTH*CHANNEL_NUM-1:0]     iv_data,
    input  logic                                   i_enable,
    output logic [CHANNEL_NUM-1:0]                 ov_bitslip,
    output logic [2*DESER_WIDTH*CHANNEL_NUM-1:0]   ov_word,
    output logic [CHANNEL_NUM-1:0]                 ov_word_valid,
    output logic [CHANNEL_NUM-1:0]                 ov_lock,
    output logic                                   o_all_lock,
    output logic [CHANNEL_NUM-1:0]                 ov_slip_wrap
);

    localparam int unsigned WW = 2 * DESER_WIDTH;
    localparam int unsigned TW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned CW = $clog2(WW);
    localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {StSearch, StSlip, StSettle, StLocked} lane_state_e;

    logic ph_q;
    logic all_lock_q;

    // One shared phase toggle serves every lane; each lane keeps its own captured copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q       <= 1'b0;
            all_lock_q <= 1'b0;
        end else begin
            ph_q       <= ~ph_q;
            all_lock_q <= &ov_lock;
        end
    end

    assign o_all_lock = all_lock_q;

    for (genvar n = 0; n < CHANNEL_NUM; n++) begin : g_lane
        logic [DESER_WIDTH-1:0] c0;
        logic [DESER_WIDTH-1:0] c1_q, c2_q, c3_q;
        lane_state_e            state_q, state_d;
        logic [TW-1:0]          tcnt_q, tcnt_d;
        logic [SW-1:0]          settle_q, settle_d;
        logic [CW-1:0]          slip_q, slip_d;
        logic [LW-1:0]          loss_q, loss_d;
        logic                   lph_q, lph_d;
        logic                   wrap_q, wrap_d;
        logic                   valid_q, valid_d;
        logic [WW-1:0]          word_q, word_d;
        logic                   hit;
        logic                   on_phase;

        assign c0       = iv_data[n*DESER_WIDTH +: DESER_WIDTH];
        assign hit      = (c3_q == '1) && (c2_q == '1) && (c1_q == '0) && (c0 == '0);
        assign on_phase = (ph_q == lph_q);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                c1_q     <= '0;
                c2_q     <= '0;
                c3_q     <= '0;
                state_q  <= StSearch;
                tcnt_q   <= '0;
                settle_q <= '0;
                slip_q   <= '0;
                loss_q   <= '0;
                lph_q    <= 1'b0;
                wrap_q   <= 1'b0;
                valid_q  <= 1'b0;
                word_q   <= '0;
            end else begin
                c1_q     <= c0;
                c2_q     <= c1_q;
                c3_q     <= c2_q;
                state_q  <= state_d;
                tcnt_q   <= tcnt_d;
                settle_q <= settle_d;
                slip_q   <= slip_d;
                loss_q   <= loss_d;
                lph_q    <= lph_d;
                wrap_q   <= wrap_d;
                valid_q  <= valid_d;
                word_q   <= word_d;
            end
        end

        always_comb begin
            state_d  = state_q;
            tcnt_d   = '0;
            settle_d = '0;
            slip_d   = slip_q;
            loss_d   = loss_q;
            lph_d    = lph_q;
            wrap_d   = wrap_q;
            valid_d  = 1'b0;
            word_d   = word_q;

            unique case (state_q)
                StSearch: begin
                    // Disabled lanes neither lock nor time out.
                    if (i_enable) begin
                        if (hit) begin
                            state_d = StLocked;
                            lph_d   = ph_q;
                            slip_d  = '0;
                            loss_d  = '0;
                        end else if (tcnt_q == TW'(SEARCH_TIMEOUT - 1)) begin
                            state_d = StSlip;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end

                StSlip: begin
                    if (slip_q == CW'(WW - 1)) begin
                        slip_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        slip_d = slip_q + 1'b1;
                    end
                    state_d = StSettle;
                end

                StSettle: begin
                    // History still holds pre-slip chunks here, so hits are ignored.
                    if (!i_enable || (settle_q == SW'(SETTLE_CYCLES - 1))) begin
                        state_d = StSearch;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end

                StLocked: begin
                    if (!i_enable) begin
                        state_d = StSearch;
                        loss_d  = '0;
                    end else begin
                        if (on_phase) begin
                            valid_d = 1'b1;
                            word_d  = {c0, c1_q};
                        end
                        if (hit && on_phase) begin
                            loss_d = '0;
                        end else if (hit) begin
                            if (loss_q == LW'(LOSS_COUNT - 1)) begin
                                state_d = StSearch;
                                loss_d  = '0;
                            end else begin
                                loss_d = loss_q + 1'b1;
                            end
                        end
                    end
                end

                default: state_d = StSearch;
            endcase
        end

        assign ov_bitslip[n]              = (state_q == StSlip);
        assign ov_lock[n]                 = (state_q == StLocked);
        assign ov_word_valid[n]           = valid_q;
        assign ov_word[n*WW +: WW]        = word_q;
        assign ov_slip_wrap[n]            = wrap_q;
    end

endmodule

// File: tb/tb_hispi_word_align.sv
// Directed bench for hispi_word_align: a bit-serial sync stream model with per-lane offset k that
// advances one bit per bitslip pulse feeds the trainer; each scenario task checks its own results.
module tb_hispi_word_align;

    localparam int CH  = 4;
    localparam int DW  = 6;
    localparam int WW  = 12;
    // Sync period (in chunks) kept inside SEARCH_TIMEOUT so an aligned lane always sees a hit.
    localparam int PER = 50;

    logic              clk;
    logic              reset;
    logic [DW*CH-1:0]  iv_data;
    logic              i_enable;
    logic [CH-1:0]     ov_bitslip;
    logic [WW*CH-1:0]  ov_word;
    logic [CH-1:0]     ov_word_valid;
    logic [CH-1:0]     ov_lock;
    logic              o_all_lock;
    logic [CH-1:0]     ov_slip_wrap;

    hispi_word_align #(
        .CHANNEL_NUM   (CH),
        .DESER_WIDTH   (DW),
        .SEARCH_TIMEOUT(64),
        .SETTLE_CYCLES (8),
        .LOSS_COUNT    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .iv_data      (iv_data),
        .i_enable     (i_enable),
        .ov_bitslip   (ov_bitslip),
        .ov_word      (ov_word),
        .ov_word_valid(ov_word_valid),
        .ov_lock      (ov_lock),
        .o_all_lock   (o_all_lock),
        .ov_slip_wrap (ov_slip_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int t;
    int k          [CH];
    bit nosig      [CH];
    int pulses     [CH];
    int last_pulse [CH];
    int min_gap    [CH];
    int vcnt       [CH];
    int cad_err    [CH];
    int bad_word   [CH];
    int lock_seen  [CH];
    bit seen_fff   [CH];
    bit seen_000   [CH];
    bit prev_valid [CH];

    // 12 ones, 12 zeros, then alternating 1010..; runs are exactly 12 so only chunk-aligned
    // sampling can produce the signature.
    function automatic logic stream_bit(input int p, input bit no_sync);
        int q;
        q = p % (PER * DW);
        if (no_sync) return logic'(p % 2 == 0);
        if (q < 12) return 1'b1;
        if (q < 24) return 1'b0;
        return logic'((q - 24) % 2 == 0);
    endfunction

    task automatic drive_data();
        for (int n = 0; n < CH; n++)
            for (int i = 0; i < DW; i++)
                iv_data[n*DW + i] = stream_bit(DW * t + k[n] + i, nosig[n]);
    endtask

    task automatic clear_stats();
        for (int n = 0; n < CH; n++) begin
            pulses[n]     = 0;
            last_pulse[n] = -100000;
            min_gap[n]    = 1000000;
            vcnt[n]       = 0;
            cad_err[n]    = 0;
            bad_word[n]   = 0;
            lock_seen[n]  = 0;
            seen_fff[n]   = 1'b0;
            seen_000[n]   = 1'b0;
            prev_valid[n] = 1'b0;
        end
    endtask

    // Advance one cycle: sample outputs at the falling edge, apply slips, present next chunk.
    task automatic step();
        logic [WW-1:0] w;
        @(negedge clk);
        for (int n = 0; n < CH; n++) begin
            if (ov_bitslip[n]) begin
                pulses[n]++;
                if (t - last_pulse[n] < min_gap[n]) min_gap[n] = t - last_pulse[n];
                last_pulse[n] = t;
                k[n]++;
            end
            if (ov_word_valid[n]) begin
                vcnt[n]++;
                if (prev_valid[n]) cad_err[n]++;
                w = ov_word[n*WW +: WW];
                if (w == 12'hFFF) seen_fff[n] = 1'b1;
                else if (w == 12'h000) seen_000[n] = 1'b1;
                else if (w != 12'h555) bad_word[n]++;
            end
            prev_valid[n] = ov_word_valid[n];
            if (ov_lock[n]) lock_seen[n]++;
        end
        t++;
        drive_data();
    endtask

    task automatic apply_reset(input int k0, input int k1, input int k2, input int k3,
                               input logic [CH-1:0] nosig_mask);
        reset    = 1'b1;
        i_enable = 1'b1;
        k[0] = k0;
        k[1] = k1;
        k[2] = k2;
        k[3] = k3;
        for (int n = 0; n < CH; n++) nosig[n] = nosig_mask[n];
        drive_data();
        repeat (3) step();
        clear_stats();
        reset = 1'b0;
    endtask

    task automatic wait_all_lock(input int budget);
        for (int i = 0; i < budget && ov_lock !== 4'hF; i++) step();
        n_checks++;
        if (ov_lock !== 4'hF) begin
            n_fail++;
            $display("FAIL all_lock_timeout: got lock=%h, expected F within %0d cycles",
                     ov_lock, budget);
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_checks++;
        if (ov_bitslip !== 4'h0) begin n_fail++; $display("FAIL rst_bitslip: got %h, expected 0", ov_bitslip); end
        n_checks++;
        if (ov_lock !== 4'h0) begin n_fail++; $display("FAIL rst_lock: got %h, expected 0", ov_lock); end
        n_checks++;
        if (ov_word_valid !== 4'h0) begin n_fail++; $display("FAIL rst_valid: got %h, expected 0", ov_word_valid); end
        n_checks++;
        if (ov_word !== 48'h0) begin n_fail++; $display("FAIL rst_word: got %h, expected 0", ov_word); end
        n_checks++;
        if (o_all_lock !== 1'b0) begin n_fail++; $display("FAIL rst_all_lock: got %b, expected 0", o_all_lock); end
        n_checks++;
        if (ov_slip_wrap !== 4'h0) begin n_fail++; $display("FAIL rst_wrap: got %h, expected 0", ov_slip_wrap); end
    endtask

    task automatic test_aligned();
        apply_reset(0, 0, 0, 0, 4'h0);
        wait_all_lock(70);
        n_checks++;
        if (o_all_lock !== 1'b0) begin n_fail++; $display("FAIL all_lock_lag: got %b, expected 0", o_all_lock); end
        step();
        n_checks++;
        if (o_all_lock !== 1'b1) begin n_fail++; $display("FAIL all_lock_set: got %b, expected 1", o_all_lock); end
        n_checks++;
        if (pulses[0] + pulses[1] + pulses[2] + pulses[3] !== 0) begin
            n_fail++;
            $display("FAIL aligned_no_slip: got %0d pulses, expected 0",
                     pulses[0] + pulses[1] + pulses[2] + pulses[3]);
        end
        clear_stats();
        repeat (100) step();
        for (int n = 0; n < CH; n++) begin
            n_checks++;
            if (vcnt[n] !== 50) begin n_fail++; $display("FAIL aligned_vcnt lane %0d: got %0d, expected 50", n, vcnt[n]); end
            n_checks++;
            if (cad_err[n] !== 0) begin n_fail++; $display("FAIL aligned_cadence lane %0d: got %0d, expected 0", n, cad_err[n]); end
            n_checks++;
            if (!(seen_fff[n] && seen_000[n])) begin
                n_fail++;
                $display("FAIL aligned_sync_words lane %0d: got fff=%0d 000=%0d, expected 1 1",
                         n, seen_fff[n], seen_000[n]);
            end
            n_checks++;
            if (bad_word[n] !== 0) begin n_fail++; $display("FAIL aligned_words lane %0d: got %0d bad, expected 0", n, bad_word[n]); end
        end
    endtask

    task automatic test_bitslip();
        apply_reset(0, 0, 3, 0, 4'h0);
        repeat (66) step();
        n_checks++;
        if (ov_lock !== 4'b1011) begin n_fail++; $display("FAIL slip_early_lock: got %h, expected b", ov_lock); end
        wait_all_lock(400);
        n_checks++;
        if (pulses[2] !== 3) begin n_fail++; $display("FAIL slip_count lane 2: got %0d, expected 3", pulses[2]); end
        n_checks++;
        if (pulses[0] + pulses[1] + pulses[3] !== 0) begin
            n_fail++;
            $display("FAIL slip_other_lanes: got %0d pulses, expected 0", pulses[0] + pulses[1] + pulses[3]);
        end
        n_checks++;
        if (min_gap[2] < 9) begin n_fail++; $display("FAIL slip_spacing: got %0d, expected >= 9", min_gap[2]); end
        clear_stats();
        repeat (100) step();
        n_checks++;
        if (vcnt[2] !== 50 || bad_word[2] !== 0 || !seen_fff[2]) begin
            n_fail++;
            $display("FAIL slip_lane2_words: got vcnt=%0d bad=%0d fff=%0d, expected 50 0 1",
                     vcnt[2], bad_word[2], seen_fff[2]);
        end
    endtask

    task automatic test_slip_wrap();
        apply_reset(0, 0, 0, 0, 4'b0010);
        for (int i = 0; i < 1000 && pulses[1] < 11; i++) step();
        repeat (3) step();
        n_checks++;
        if (ov_slip_wrap !== 4'h0) begin n_fail++; $display("FAIL wrap_early: got %h after 11 slips, expected 0", ov_slip_wrap); end
        for (int i = 0; i < 100 && pulses[1] < 12; i++) step();
        step();
        n_checks++;
        if (ov_slip_wrap !== 4'b0010) begin n_fail++; $display("FAIL wrap_set: got %h after %0d slips, expected 2", ov_slip_wrap, pulses[1]); end
        for (int i = 0; i < 200 && pulses[1] < 14; i++) step();
        n_checks++;
        if (pulses[1] !== 14) begin n_fail++; $display("FAIL wrap_continue: got %0d slips, expected 14", pulses[1]); end
        n_checks++;
        if (ov_slip_wrap !== 4'b0010) begin n_fail++; $display("FAIL wrap_sticky: got %h, expected 2", ov_slip_wrap); end
        n_checks++;
        if (ov_lock !== 4'b1101) begin n_fail++; $display("FAIL wrap_other_lock: got %h, expected d", ov_lock); end
        n_checks++;
        if (min_gap[1] < 9) begin n_fail++; $display("FAIL wrap_spacing: got %0d, expected >= 9", min_gap[1]); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (ov_slip_wrap !== 4'h0) begin n_fail++; $display("FAIL wrap_clear: got %h, expected 0", ov_slip_wrap); end
    endtask

    task automatic test_loss();
        int drop_at;
        apply_reset(0, 0, 0, 0, 4'h0);
        wait_all_lock(70);
        for (int i = 0; i < PER && (t % PER) != 10; i++) step();
        k[0] = k[0] + DW;
        drive_data();
        clear_stats();
        drop_at = -1;
        for (int i = 0; i < 210; i++) begin
            step();
            if (drop_at < 0 && ov_lock[0] == 1'b0) drop_at = i + 1;
        end
        n_checks++;
        if (drop_at <= 150 || drop_at > 202) begin
            n_fail++;
            $display("FAIL loss_drop_time: got %0d, expected in (150,202]", drop_at);
        end
        for (int n = 1; n < CH; n++) begin
            n_checks++;
            if (vcnt[n] !== 105 || lock_seen[n] !== 210) begin
                n_fail++;
                $display("FAIL loss_other_lane %0d: got vcnt=%0d lock=%0d, expected 105 210",
                         n, vcnt[n], lock_seen[n]);
            end
        end
        clear_stats();
        for (int i = 0; i < 60 && ov_lock[0] !== 1'b1; i++) step();
        n_checks++;
        if (ov_lock[0] !== 1'b1) begin n_fail++; $display("FAIL loss_relock: got %b, expected 1", ov_lock[0]); end
        n_checks++;
        if (pulses[0] !== 0) begin n_fail++; $display("FAIL loss_relock_slips: got %0d, expected 0", pulses[0]); end
        clear_stats();
        repeat (100) step();
        n_checks++;
        if (vcnt[0] !== 50 || bad_word[0] !== 0 || !seen_fff[0] || !seen_000[0]) begin
            n_fail++;
            $display("FAIL loss_new_phase: got vcnt=%0d bad=%0d fff=%0d 000=%0d, expected 50 0 1 1",
                     vcnt[0], bad_word[0], seen_fff[0], seen_000[0]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(0, 0, 0, 1, 4'h0);
        for (int i = 0; i < 100 && pulses[3] < 1; i++) step();
        n_checks++;
        if (ov_bitslip !== 4'b1000) begin n_fail++; $display("FAIL mid_in_slip: got %h, expected 8", ov_bitslip); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (ov_bitslip !== 4'h0 || ov_lock !== 4'h0 || ov_word_valid !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: got slip=%h lock=%h valid=%h, expected 0 0 0",
                     ov_bitslip, ov_lock, ov_word_valid);
        end
        n_checks++;
        if (ov_word !== 48'h0 || o_all_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_data: got word=%h all=%b, expected 0 0", ov_word, o_all_lock);
        end
        repeat (3) step();
        clear_stats();
        reset = 1'b0;
        step();
        n_checks++;
        if (ov_bitslip !== 4'h0) begin n_fail++; $display("FAIL mid_release_slip: got %h, expected 0", ov_bitslip); end
        wait_all_lock(600);
        n_checks++;
        if (pulses[3] !== 4) begin n_fail++; $display("FAIL mid_relock_slips: got %0d, expected 4", pulses[3]); end
        n_checks++;
        if (min_gap[3] < 9) begin n_fail++; $display("FAIL mid_spacing: got %0d, expected >= 9", min_gap[3]); end
    endtask

    task automatic test_enable();
        i_enable = 1'b0;
        clear_stats();
        step();
        n_checks++;
        if (ov_lock !== 4'h0) begin n_fail++; $display("FAIL dis_unlock: got %h, expected 0", ov_lock); end
        repeat (2000) step();
        for (int n = 0; n < CH; n++) begin
            n_checks++;
            if (lock_seen[n] !== 0 || pulses[n] !== 0 || vcnt[n] !== 0) begin
                n_fail++;
                $display("FAIL dis_quiet lane %0d: got lock=%0d slips=%0d valid=%0d, expected 0 0 0",
                         n, lock_seen[n], pulses[n], vcnt[n]);
            end
        end
        n_checks++;
        if (o_all_lock !== 1'b0) begin n_fail++; $display("FAIL dis_all_lock: got %b, expected 0", o_all_lock); end
        i_enable = 1'b1;
        clear_stats();
        wait_all_lock(70);
        n_checks++;
        if (pulses[0] + pulses[1] + pulses[2] + pulses[3] !== 0) begin
            n_fail++;
            $display("FAIL en_relock_slips: got %0d, expected 0",
                     pulses[0] + pulses[1] + pulses[2] + pulses[3]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        t        = 0;
        reset    = 1'b1;
        i_enable = 1'b1;
        for (int n = 0; n < CH; n++) begin
            k[n]     = 0;
            nosig[n] = 1'b0;
        end
        clear_stats();
        drive_data();

        test_reset();
        test_aligned();
        test_bitslip();
        test_slip_wrap();
        test_loss();
        test_reset_mid();
        test_enable();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
